// File: rtl/calc1_response_checker.sv
// ---------------------------------------------------------------------------
// calc1_response_checker
//
// Passive checker for the four-port calc1 request/response interface. Each
// port snoops a command (cmd + op1), then op2 on the following cycle, works
// out the response it should see, and compares it against out_resp/out_data.
// Errors are reported per port and pass/fail totals are kept.
//
// Ports
//   c_clk            in   clock, all state updates on the rising edge
//   reset[1:7]       in   synchronous, active-high, any bit set resets
//   req_cmd_inN      in   per-port command (0 = no-op)
//   req_data_inN     in   per-port operand (op1 with cmd, op2 next cycle)
//   out_respN        in   response code (0 none, 1 ok, 2 over/underflow, 3 invalid)
//   out_dataN        in   response data, meaningful when resp = 1
//   busy[1:4]        out  port has a command outstanding
//   err_valid[1:4]   out  one-cycle pulse, error seen on that port
//   err_code[0:11]   out  3 bits per port (port1 = [0:2] .. port4 = [9:11])
//   pass_count       out  saturating count of matched responses
//   fail_count       out  saturating count of reported errors
//
// Error codes: 1 wrong resp, 2 wrong data, 3 timeout, 4 spurious resp,
//              5 command while busy.
//
// Per-port FSM
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | nothing outstanding; a command latches op1
//   S_OP2  | op2 on the bus this cycle; expected result computed and held
//   S_WAIT | waiting for the response, timeout timer running
// ---------------------------------------------------------------------------
module calc1_response_checker #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             c_clk,
    input  logic [1:7]       reset,
    input  logic [0:3]       req_cmd_in1,
    input  logic [0:3]       req_cmd_in2,
    input  logic [0:3]       req_cmd_in3,
    input  logic [0:3]       req_cmd_in4,
    input  logic [0:31]      req_data_in1,
    input  logic [0:31]      req_data_in2,
    input  logic [0:31]      req_data_in3,
    input  logic [0:31]      req_data_in4,
    input  logic [0:1]       out_resp1,
    input  logic [0:1]       out_resp2,
    input  logic [0:1]       out_resp3,
    input  logic [0:1]       out_resp4,
    input  logic [0:31]      out_data1,
    input  logic [0:31]      out_data2,
    input  logic [0:31]      out_data3,
    input  logic [0:31]      out_data4,
    output logic [1:4]       busy,
    output logic [1:4]       err_valid,
    output logic [0:11]      err_code,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OP2  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    logic rst;
    assign rst = |reset;

    // Ports gathered into arrays so the four FSMs can be generated.
    logic [3:0]  cmd_a   [4];
    logic [31:0] op_a    [4];
    logic [1:0]  resp_a  [4];
    logic [31:0] rdata_a [4];

    assign cmd_a[0]   = req_cmd_in1;
    assign cmd_a[1]   = req_cmd_in2;
    assign cmd_a[2]   = req_cmd_in3;
    assign cmd_a[3]   = req_cmd_in4;
    assign op_a[0]    = req_data_in1;
    assign op_a[1]    = req_data_in2;
    assign op_a[2]    = req_data_in3;
    assign op_a[3]    = req_data_in4;
    assign resp_a[0]  = out_resp1;
    assign resp_a[1]  = out_resp2;
    assign resp_a[2]  = out_resp3;
    assign resp_a[3]  = out_resp4;
    assign rdata_a[0] = out_data1;
    assign rdata_a[1] = out_data2;
    assign rdata_a[2] = out_data3;
    assign rdata_a[3] = out_data4;

    logic [3:0] ev_pass;
    logic [3:0] ev_err;
    logic [2:0] ev_code [4];

    // Returns {expected resp, expected data}; data is zero when resp != 1.
    function automatic logic [33:0] calc_expected(input logic [3:0]  cmd,
                                                  input logic [31:0] op1,
                                                  input logic [31:0] op2);
        logic [32:0] sum;
        logic [4:0]  amt;
        logic [33:0] r;
        sum = {1'b0, op1} + {1'b0, op2};
        amt = op2[4:0];
        case (cmd)
            4'd1:    r = sum[32] ? {2'd2, 32'd0} : {2'd1, sum[31:0]};
            4'd2:    r = (op2 > op1) ? {2'd2, 32'd0} : {2'd1, op1 - op2};
            4'd5:    r = {2'd1, op1 << amt};
            4'd6:    r = {2'd1, op1 >> amt};
            default: r = {2'd3, 32'd0};
        endcase
        return r;
    endfunction

    for (genvar p = 0; p < 4; p++) begin : g_port
        state_t             state_q, state_d;
        logic [3:0]         cmd_q, cmd_d;
        logic [31:0]        op1_q, op1_d;
        logic [1:0]         exp_resp_q, exp_resp_d;
        logic [31:0]        exp_data_q, exp_data_d;
        logic [TMR_W-1:0]   tmr_q, tmr_d;
        logic [33:0]        exp_calc;
        logic               pass_p, err_p;
        logic [2:0]         code_p;

        assign exp_calc   = calc_expected(cmd_q, op1_q, op_a[p]);
        assign busy[p+1]  = (state_q != S_IDLE);
        assign ev_pass[p] = pass_p;
        assign ev_err[p]  = err_p;
        assign ev_code[p] = code_p;

        always_ff @(posedge c_clk) begin
            if (rst) begin
                state_q    <= S_IDLE;
                cmd_q      <= '0;
                op1_q      <= '0;
                exp_resp_q <= '0;
                exp_data_q <= '0;
                tmr_q      <= '0;
            end else begin
                state_q    <= state_d;
                cmd_q      <= cmd_d;
                op1_q      <= op1_d;
                exp_resp_q <= exp_resp_d;
                exp_data_q <= exp_data_d;
                tmr_q      <= tmr_d;
            end
        end

        always_comb begin
            state_d    = state_q;
            cmd_d      = cmd_q;
            op1_d      = op1_q;
            exp_resp_d = exp_resp_q;
            exp_data_d = exp_data_q;
            tmr_d      = tmr_q;
            pass_p     = 1'b0;
            err_p      = 1'b0;
            code_p     = 3'd0;
            case (state_q)
                S_IDLE: begin
                    if (resp_a[p] != 2'd0) begin
                        err_p  = 1'b1;
                        code_p = 3'd4;
                    end
                    if (cmd_a[p] != 4'd0) begin
                        cmd_d   = cmd_a[p];
                        op1_d   = op_a[p];
                        state_d = S_OP2;
                    end
                end
                S_OP2: begin
                    if (resp_a[p] != 2'd0) begin
                        err_p  = 1'b1;
                        code_p = 3'd4;
                    end
                    exp_resp_d = exp_calc[33:32];
                    exp_data_d = exp_calc[31:0];
                    // Down-counter: terminal count hit on the TIMEOUT-th WAIT cycle.
                    tmr_d      = TMR_W'(TIMEOUT - 1);
                    state_d    = S_WAIT;
                end
                S_WAIT: begin
                    if (resp_a[p] != 2'd0) begin
                        if (resp_a[p] != exp_resp_q) begin
                            err_p  = 1'b1;
                            code_p = 3'd1;
                        end else if (resp_a[p] == 2'd1 && rdata_a[p] != exp_data_q) begin
                            err_p  = 1'b1;
                            code_p = 3'd2;
                        end else begin
                            pass_p = 1'b1;
                        end
                        state_d = S_IDLE;
                        // A command alongside the response starts the next transaction.
                        if (cmd_a[p] != 4'd0) begin
                            cmd_d   = cmd_a[p];
                            op1_d   = op_a[p];
                            state_d = S_OP2;
                        end
                    end else if (tmr_q == '0) begin
                        err_p   = 1'b1;
                        code_p  = 3'd3;
                        state_d = S_IDLE;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                        if (cmd_a[p] != 4'd0) begin
                            err_p  = 1'b1;
                            code_p = 3'd5;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    logic [2:0] n_pass;
    logic [2:0] n_fail;

    always_comb begin
        n_pass = '0;
        n_fail = '0;
        for (int p = 0; p < 4; p++) begin
            n_pass = n_pass + {2'b00, ev_pass[p]};
            n_fail = n_fail + {2'b00, ev_err[p]};
        end
    end

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                 input logic [2:0]       n);
        logic [CNT_W:0] s;
        s = {1'b0, c} + (CNT_W+1)'(n);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    always_ff @(posedge c_clk) begin
        if (rst) begin
            err_valid  <= '0;
            err_code   <= '0;
            pass_count <= '0;
            fail_count <= '0;
        end else begin
            for (int p = 0; p < 4; p++) begin
                err_valid[p+1] <= ev_err[p];
                if (ev_err[p])
                    err_code[3*p +: 3] <= ev_code[p];
            end
            pass_count <= sat_add(pass_count, n_pass);
            fail_count <= sat_add(fail_count, n_fail);
        end
    end

endmodule

// File: tb/tb_calc1_response_checker.sv
module tb_calc1_response_checker;

    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 8;
    localparam int CMAX    = 255;

    logic             c_clk;
    logic [1:7]       t_reset;
    logic [3:0]       t_cmd   [4];
    logic [31:0]      t_data  [4];
    logic [1:0]       t_resp  [4];
    logic [31:0]      t_rdata [4];
    logic [1:4]       busy;
    logic [1:4]       err_valid;
    logic [0:11]      err_code;
    logic [CNT_W-1:0] pass_count;
    logic [CNT_W-1:0] fail_count;

    int checks = 0;
    int errors = 0;

    // Reference model: transaction view per port.
    // m_phase 0 = nothing outstanding, 1 = op2 due, 2 = response awaited.
    int          m_phase   [4];
    int          m_waited  [4];
    int          m_cmd     [4];
    logic [31:0] m_op1     [4];
    int          m_exp_resp[4];
    logic [31:0] m_exp_data[4];
    logic [1:4]  m_err_valid;
    logic [0:11] m_err_code;
    int          m_pass;
    int          m_fail;

    calc1_response_checker #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .c_clk        (c_clk),
        .reset        (t_reset),
        .req_cmd_in1  (t_cmd[0]),
        .req_cmd_in2  (t_cmd[1]),
        .req_cmd_in3  (t_cmd[2]),
        .req_cmd_in4  (t_cmd[3]),
        .req_data_in1 (t_data[0]),
        .req_data_in2 (t_data[1]),
        .req_data_in3 (t_data[2]),
        .req_data_in4 (t_data[3]),
        .out_resp1    (t_resp[0]),
        .out_resp2    (t_resp[1]),
        .out_resp3    (t_resp[2]),
        .out_resp4    (t_resp[3]),
        .out_data1    (t_rdata[0]),
        .out_data2    (t_rdata[1]),
        .out_data3    (t_rdata[2]),
        .out_data4    (t_rdata[3]),
        .busy         (busy),
        .err_valid    (err_valid),
        .err_code     (err_code),
        .pass_count   (pass_count),
        .fail_count   (fail_count)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic expected_of(input int cmd, input logic [31:0] a, input logic [31:0] b,
                               output int r, output logic [31:0] d);
        longint unsigned s;
        int amt;
        amt = int'(b % 32);
        d = 32'd0;
        case (cmd)
            1: begin
                s = 64'(a) + 64'(b);
                if (s > 64'hFFFF_FFFF) r = 2;
                else begin r = 1; d = s[31:0]; end
            end
            2: if (b > a) r = 2; else begin r = 1; d = a - b; end
            5: begin r = 1; d = a << amt; end
            6: begin r = 1; d = a >> amt; end
            default: r = 3;
        endcase
    endtask

    task automatic model_update();
        int np, nf, code;
        bit ev;
        np = 0;
        nf = 0;
        if (t_reset != 7'd0) begin
            for (int p = 0; p < 4; p++) begin
                m_phase[p] = 0;
                m_waited[p] = 0;
            end
            m_err_valid = '0;
            m_err_code  = '0;
            m_pass = 0;
            m_fail = 0;
            return;
        end
        for (int p = 0; p < 4; p++) begin
            ev = 1'b0;
            code = 0;
            if (m_phase[p] == 0) begin
                if (t_resp[p] != 0) begin ev = 1'b1; code = 4; end
                if (t_cmd[p] != 0) begin
                    m_cmd[p] = int'(t_cmd[p]); m_op1[p] = t_data[p]; m_phase[p] = 1;
                end
            end else if (m_phase[p] == 1) begin
                if (t_resp[p] != 0) begin ev = 1'b1; code = 4; end
                expected_of(m_cmd[p], m_op1[p], t_data[p], m_exp_resp[p], m_exp_data[p]);
                m_phase[p] = 2;
                m_waited[p] = 0;
            end else begin
                m_waited[p]++;
                if (t_resp[p] != 0) begin
                    if (int'(t_resp[p]) != m_exp_resp[p]) begin ev = 1'b1; code = 1; end
                    else if (t_resp[p] == 1 && t_rdata[p] != m_exp_data[p]) begin ev = 1'b1; code = 2; end
                    else np++;
                    m_phase[p] = 0;
                    if (t_cmd[p] != 0) begin
                        m_cmd[p] = int'(t_cmd[p]); m_op1[p] = t_data[p]; m_phase[p] = 1;
                    end
                end else if (m_waited[p] == TIMEOUT) begin
                    ev = 1'b1; code = 3; m_phase[p] = 0;
                end else if (t_cmd[p] != 0) begin
                    ev = 1'b1; code = 5;
                end
            end
            m_err_valid[p+1] = ev;
            if (ev) begin
                m_err_code[3*p +: 3] = 3'(code);
                nf++;
            end
        end
        m_pass = (m_pass + np > CMAX) ? CMAX : m_pass + np;
        m_fail = (m_fail + nf > CMAX) ? CMAX : m_fail + nf;
    endtask

    task automatic idle_inputs();
        for (int p = 0; p < 4; p++) begin
            t_cmd[p] = 4'd0; t_data[p] = 32'd0; t_resp[p] = 2'd0; t_rdata[p] = 32'd0;
        end
    endtask

    task automatic step();
        @(posedge c_clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        t_reset = 7'b0000001;
        step();
        t_reset = 7'd0;
    endtask

    task automatic test_reset();
        for (int p = 0; p < 4; p++) begin
            t_cmd[p] = 4'd1; t_data[p] = $urandom; t_resp[p] = 2'd1; t_rdata[p] = $urandom;
        end
        t_reset = 7'b1000000;
        step();
        step();
        checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL reset_busy: got %b expected 0000", busy); end
        checks++; if (err_valid !== 4'b0000) begin errors++; $display("FAIL reset_err_valid: got %b expected 0000", err_valid); end
        checks++; if (err_code !== 12'h000) begin errors++; $display("FAIL reset_err_code: got %h expected 000", err_code); end
        checks++; if (pass_count !== 8'd0 || fail_count !== 8'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", pass_count, fail_count); end
        idle_inputs();
        t_reset = 7'd0;
        step();
        checks++; if (busy !== 4'b0000 || err_valid !== 4'b0000) begin errors++; $display("FAIL reset_release: busy %b err_valid %b expected 0000/0000", busy, err_valid); end
    endtask

    task automatic test_add_pass();
        do_reset();
        t_cmd[0] = 4'd1; t_data[0] = 32'd5; step();
        checks++; if (busy[1] !== 1'b1) begin errors++; $display("FAIL add_busy: got %b expected 1", busy[1]); end
        t_cmd[0] = 4'd0; t_data[0] = 32'd7; step();
        t_data[0] = 32'd0; step();
        t_resp[0] = 2'd1; t_rdata[0] = 32'd12; step();
        idle_inputs();
        checks++; if (pass_count !== 8'd1) begin errors++; $display("FAIL add_pass_count: got %0d expected 1", pass_count); end
        checks++; if (err_valid !== 4'b0000) begin errors++; $display("FAIL add_no_err: got %b expected 0000", err_valid); end
        checks++; if (busy[1] !== 1'b0) begin errors++; $display("FAIL add_idle: got %b expected 0", busy[1]); end
    endtask

    task automatic test_add_overflow();
        logic [2:0] c;
        do_reset();
        t_cmd[1] = 4'd1; t_data[1] = 32'hFFFF_FFFF; step();
        t_cmd[1] = 4'd0; t_data[1] = 32'd1; step();
        t_data[1] = 32'd0; t_resp[1] = 2'd1; t_rdata[1] = 32'd0; step();
        idle_inputs();
        c = err_code[3:5];
        checks++; if (err_valid !== 4'b0100) begin errors++; $display("FAIL ovf_err_valid: got %b expected 0100", err_valid); end
        checks++; if (c !== 3'd1) begin errors++; $display("FAIL ovf_err_code: got %0d expected 1", c); end
        checks++; if (fail_count !== 8'd1) begin errors++; $display("FAIL ovf_fail_count: got %0d expected 1", fail_count); end
        step();
        c = err_code[3:5];
        checks++; if (err_valid !== 4'b0000 || c !== 3'd1) begin errors++; $display("FAIL ovf_pulse_hold: err_valid %b code %0d expected 0000/1", err_valid, c); end
    endtask

    task automatic test_shift_sub();
        logic [2:0] c;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            t_cmd[2] = 4'd5; t_data[2] = 32'h1; step();
            t_cmd[2] = 4'd0; t_data[2] = 32'h21; step();
            t_data[2] = 32'd0; t_resp[2] = 2'd1; t_rdata[2] = (k == 0) ? 32'h3 : 32'h2; step();
            idle_inputs();
            c = err_code[6:8];
            if (k == 0) begin
                checks++; if (err_valid !== 4'b0010 || c !== 3'd2) begin errors++; $display("FAIL shl_bad_data: err_valid %b code %0d expected 0010/2", err_valid, c); end
            end else begin
                checks++; if (err_valid !== 4'b0000 || pass_count !== 8'd1) begin errors++; $display("FAIL shl_good_data: err_valid %b pass %0d expected 0000/1", err_valid, pass_count); end
            end
        end
        t_cmd[2] = 4'd2; t_data[2] = 32'd3; step();
        t_cmd[2] = 4'd0; t_data[2] = 32'd5; step();
        t_data[2] = 32'd0; t_resp[2] = 2'd2; t_rdata[2] = $urandom; step();
        idle_inputs();
        checks++; if (err_valid !== 4'b0000 || pass_count !== 8'd2 || fail_count !== 8'd1) begin errors++; $display("FAIL sub_underflow: err_valid %b pass %0d fail %0d expected 0000/2/1", err_valid, pass_count, fail_count); end
    endtask

    task automatic test_timeout();
        logic [2:0] c;
        do_reset();
        t_cmd[3] = 4'd2; t_data[3] = 32'd9; step();
        t_cmd[3] = 4'd0; t_data[3] = 32'd4; step();
        t_data[3] = 32'd0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            step();
            if (k < TIMEOUT) begin
                checks++; if (err_valid[4] !== 1'b0 || busy[4] !== 1'b1) begin errors++; $display("FAIL timeout_wait_%0d: err_valid %b busy %b expected 0/1", k, err_valid[4], busy[4]); end
            end
        end
        c = err_code[9:11];
        checks++; if (err_valid[4] !== 1'b1 || c !== 3'd3) begin errors++; $display("FAIL timeout_err: err_valid %b code %0d expected 1/3", err_valid[4], c); end
        checks++; if (busy[4] !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b expected 0", busy[4]); end
        t_resp[3] = 2'd1; t_rdata[3] = 32'd5; step();
        idle_inputs();
        c = err_code[9:11];
        checks++; if (err_valid !== 4'b0001 || c !== 3'd4 || fail_count !== 8'd2) begin errors++; $display("FAIL late_resp: err_valid %b code %0d fail %0d expected 0001/4/2", err_valid, c, fail_count); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] c;
        do_reset();
        t_cmd[0] = 4'd1; t_data[0] = 32'd10; step();
        t_cmd[0] = 4'd0; t_data[0] = 32'd20; step();
        t_resp[0] = 2'd1; t_rdata[0] = 32'd30; t_cmd[0] = 4'd2; t_data[0] = 32'd100; step();
        checks++; if (err_valid !== 4'b0000 || busy[1] !== 1'b1 || pass_count !== 8'd1) begin errors++; $display("FAIL b2b_accept: err_valid %b busy %b pass %0d expected 0000/1/1", err_valid, busy[1], pass_count); end
        t_resp[0] = 2'd0; t_cmd[0] = 4'd0; t_data[0] = 32'd1; step();
        t_resp[0] = 2'd1; t_rdata[0] = 32'd99; t_data[0] = 32'd0; step();
        checks++; if (err_valid !== 4'b0000 || pass_count !== 8'd2) begin errors++; $display("FAIL b2b_second: err_valid %b pass %0d expected 0000/2", err_valid, pass_count); end
        t_resp[0] = 2'd0; t_cmd[0] = 4'd6; t_data[0] = 32'h80; step();
        t_cmd[0] = 4'd0; t_data[0] = 32'd3; step();
        t_cmd[0] = 4'd1; t_data[0] = 32'd7; step();
        c = err_code[0:2];
        checks++; if (err_valid !== 4'b1000 || c !== 3'd5 || busy[1] !== 1'b1) begin errors++; $display("FAIL busy_cmd: err_valid %b code %0d busy %b expected 1000/5/1", err_valid, c, busy[1]); end
        t_cmd[0] = 4'd0; t_resp[0] = 2'd1; t_rdata[0] = 32'h10; step();
        idle_inputs();
        checks++; if (err_valid !== 4'b0000 || pass_count !== 8'd3 || fail_count !== 8'd1) begin errors++; $display("FAIL busy_cmd_discard: err_valid %b pass %0d fail %0d expected 0000/3/1", err_valid, pass_count, fail_count); end
    endtask

    task automatic test_reset_mid();
        logic [2:0] c;
        do_reset();
        t_cmd[0] = 4'd1; t_data[0] = 32'd5; step();
        t_cmd[0] = 4'd0; t_data[0] = 32'd7; step();
        t_data[0] = 32'd0; step();
        checks++; if (busy[1] !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy[1]); end
        t_reset = 7'b0010000; step();
        t_reset = 7'd0;
        checks++; if (busy !== 4'b0000 || err_valid !== 4'b0000 || fail_count !== 8'd0) begin errors++; $display("FAIL mid_reset: busy %b err_valid %b fail %0d expected 0000/0000/0", busy, err_valid, fail_count); end
        t_resp[0] = 2'd1; t_rdata[0] = 32'd12; t_cmd[0] = 4'd5; t_data[0] = 32'd3; step();
        c = err_code[0:2];
        checks++; if (err_valid !== 4'b1000 || c !== 3'd4 || busy[1] !== 1'b1) begin errors++; $display("FAIL mid_spurious: err_valid %b code %0d busy %b expected 1000/4/1", err_valid, c, busy[1]); end
        t_resp[0] = 2'd0; t_cmd[0] = 4'd0; t_data[0] = 32'd2; step();
        t_resp[0] = 2'd1; t_rdata[0] = 32'd12; t_data[0] = 32'd0; step();
        idle_inputs();
        checks++; if (err_valid !== 4'b0000 || pass_count !== 8'd1) begin errors++; $display("FAIL mid_new_cmd: err_valid %b pass %0d expected 0000/1", err_valid, pass_count); end
    endtask

    task automatic test_random();
        int r;
        logic [1:4] eb;
        do_reset();
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int p = 0; p < 4; p++) begin
                r = $urandom_range(0, 9);
                t_cmd[p] = 4'd0; t_data[p] = $urandom; t_resp[p] = 2'd0; t_rdata[p] = $urandom;
                if (m_phase[p] == 0) begin
                    if (r < 4) begin
                        case ($urandom_range(0, 6))
                            0: t_cmd[p] = 4'd1;
                            1: t_cmd[p] = 4'd2;
                            2: t_cmd[p] = 4'd5;
                            3: t_cmd[p] = 4'd6;
                            4: t_cmd[p] = 4'd3;
                            5: t_cmd[p] = 4'd15;
                            default: t_cmd[p] = 4'd1;
                        endcase
                    end else if (r == 9) t_resp[p] = 2'($urandom_range(1, 3));
                end else if (m_phase[p] == 1) begin
                    if (r < 5) t_data[p] = $urandom_range(0, 40);
                end else begin
                    if (r < 3 || r == 5) begin
                        t_resp[p] = 2'(m_exp_resp[p]);
                        t_rdata[p] = m_exp_data[p];
                        if (r == 5) t_cmd[p] = 4'd1;
                    end else if (r == 3) begin
                        t_resp[p] = 2'($urandom_range(1, 3));
                        t_rdata[p] = m_exp_data[p] ^ 32'($urandom_range(0, 1));
                    end else if (r == 4) t_cmd[p] = 4'd6;
                end
            end
            step();
            for (int p = 0; p < 4; p++) eb[p+1] = (m_phase[p] != 0);
            checks++; if (busy !== eb) begin errors++; $display("FAIL rnd_busy cyc %0d: got %b expected %b", cyc, busy, eb); end
            checks++; if (err_valid !== m_err_valid) begin errors++; $display("FAIL rnd_err_valid cyc %0d: got %b expected %b", cyc, err_valid, m_err_valid); end
            checks++; if (err_code !== m_err_code) begin errors++; $display("FAIL rnd_err_code cyc %0d: got %h expected %h", cyc, err_code, m_err_code); end
            checks++; if (pass_count !== CNT_W'(m_pass) || fail_count !== CNT_W'(m_fail)) begin errors++; $display("FAIL rnd_counts cyc %0d: got %0d/%0d expected %0d/%0d", cyc, pass_count, fail_count, m_pass, m_fail); end
        end
        idle_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int rnd = 0; rnd < 66; rnd++) begin
            for (int p = 0; p < 4; p++) begin
                case ($urandom_range(0, 4))
                    0: t_cmd[p] = 4'd1;
                    1: t_cmd[p] = 4'd2;
                    2: t_cmd[p] = 4'd5;
                    3: t_cmd[p] = 4'd6;
                    default: t_cmd[p] = 4'd4;
                endcase
                t_data[p] = $urandom;
            end
            step();
            for (int p = 0; p < 4; p++) begin t_cmd[p] = 4'd0; t_data[p] = $urandom; end
            step();
            for (int p = 0; p < 4; p++) begin
                t_data[p] = 32'd0;
                t_resp[p] = 2'(m_exp_resp[p]);
                t_rdata[p] = (m_exp_resp[p] == 1) ? m_exp_data[p] : $urandom;
            end
            step();
            idle_inputs();
            checks++; if (err_valid !== 4'b0000 || pass_count !== CNT_W'(m_pass)) begin errors++; $display("FAIL sat_round %0d: err_valid %b pass %0d expected 0000/%0d", rnd, err_valid, pass_count, m_pass); end
            if (rnd == 0) begin
                checks++; if (pass_count !== 8'd4) begin errors++; $display("FAIL four_at_once: got %0d expected 4", pass_count); end
            end
        end
        checks++; if (pass_count !== 8'hFF) begin errors++; $display("FAIL pass_saturate: got %0d expected 255", pass_count); end
    endtask

    initial begin
        t_reset = 7'd0;
        idle_inputs();
        for (int p = 0; p < 4; p++) begin
            m_phase[p] = 0; m_waited[p] = 0; m_cmd[p] = 0; m_op1[p] = 0;
            m_exp_resp[p] = 0; m_exp_data[p] = 0;
        end
        m_err_valid = '0; m_err_code = '0; m_pass = 0; m_fail = 0;
        #1;
        test_reset();
        test_add_pass();
        test_add_overflow();
        test_shift_sub();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
